// File: rtl/i2s_tx_master.sv
// -----------------------------------------------------------------------------
// i2s_tx_master
//   Philips I2S master transmitter. Derives bclk/lrclk from sysclk and shifts
//   2's-complement stereo samples MSB-first on dout, one bclk after each lrclk
//   edge. A one-deep holding register decouples the producer from the frame
//   timing; its contents move into the shifters at every frame boundary.
//
// Ports
//   sysclk    in   system clock (only clock)
//   reset     in   synchronous, active-high
//   enable    in   1 = run the interface, 0 = idle with counters cleared
//   in_left   in   left sample  [DATA_WIDTH]
//   in_right  in   right sample [DATA_WIDTH]
//   in_valid  in   sample pair valid
//   in_ready  out  holding register can take a pair this cycle
//   bclk      out  bit clock (registered)
//   lrclk     out  word select, 0 = left slot, 1 = right slot (registered)
//   dout      out  serial data, updated on bclk falling toggles (registered)
//   underrun  out  1-cycle pulse when a frame is loaded with no pair available
// -----------------------------------------------------------------------------
module i2s_tx_master #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int CLKDIV     = 21
) (
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] in_left,
  input  logic [DATA_WIDTH-1:0] in_right,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  dout,
  output logic                  underrun
);

  localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_WIDTH);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLKDIV - 1);
  localparam logic [BIT_W-1:0] FRAME_LAST = BIT_W'(2 * SLOT_WIDTH - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN   = BIT_W'(SLOT_WIDTH);
  localparam logic [BIT_W-1:0] DATA_LEN   = BIT_W'(DATA_WIDTH);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t                r_state;
  logic [DIV_W-1:0]      r_div;
  logic [BIT_W-1:0]      r_bitcnt;
  logic                  r_bclk;
  logic                  r_lrclk;
  logic                  r_dout;
  logic                  r_underrun;
  logic                  r_hold_full;
  logic [DATA_WIDTH-1:0] r_hold_left;
  logic [DATA_WIDTH-1:0] r_hold_right;
  logic [DATA_WIDTH-1:0] r_sh_left;
  logic [DATA_WIDTH-1:0] r_sh_right;

  logic             w_tick;
  logic             w_fall;
  logic             w_load;
  logic             w_ready;
  logic             w_accept;
  logic [BIT_W-1:0] w_bit_next;
  logic             w_lr_next;
  logic [BIT_W-1:0] w_pos_next;
  logic             w_data_slot;

  // Position the next falling toggle will move to: slot select and the bit
  // position inside the slot. Position 0 is the I2S one-bclk delay slot.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_bit_next  = '0;
    w_lr_next   = 1'b0;
    w_pos_next  = '0;
    w_data_slot = 1'b0;
    if (r_bitcnt != FRAME_LAST) begin
      w_bit_next = r_bitcnt + BIT_W'(1);
    end
    w_lr_next   = (w_bit_next >= SLOT_LEN);
    w_pos_next  = w_lr_next ? (w_bit_next - SLOT_LEN) : w_bit_next;
    w_data_slot = (w_pos_next != '0) && (w_pos_next <= DATA_LEN);
  end

  assign w_tick = (r_div == DIV_LAST);
  assign w_fall = (r_state == ST_RUN) && enable && w_tick && r_bclk;

  // Frame load: leaving IDLE, or the falling toggle that wraps bitcnt to 0.
  assign w_load = !reset && enable &&
                  ((r_state == ST_IDLE) || (w_fall && (r_bitcnt == FRAME_LAST)));

  // A full hold can still take a pair in the cycle it is emptied by a load.
  assign w_ready  = !reset && (!r_hold_full || w_load);
  assign w_accept = in_valid && w_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_div        <= '0;
      r_bitcnt     <= '0;
      r_bclk       <= 1'b0;
      r_lrclk      <= 1'b0;
      r_dout       <= 1'b0;
      r_underrun   <= 1'b0;
      r_hold_full  <= 1'b0;
      r_hold_left  <= '0;
      r_hold_right <= '0;
      r_sh_left    <= '0;
      r_sh_right   <= '0;
    end else begin
      r_underrun <= 1'b0;

      // Holding register: an accept in a load cycle refills what the load takes.
      if (w_accept) begin
        r_hold_left  <= in_left;
        r_hold_right <= in_right;
        r_hold_full  <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end

      // Loads never coincide with a shift: the wrap lands on position 0.
      if (w_load) begin
        if (r_hold_full) begin
          r_sh_left  <= r_hold_left;
          r_sh_right <= r_hold_right;
        end else begin
          r_sh_left  <= '0;
          r_sh_right <= '0;
          r_underrun <= 1'b1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          r_div    <= '0;
          r_bitcnt <= '0;
          r_bclk   <= 1'b0;
          r_lrclk  <= 1'b0;
          r_dout   <= 1'b0;
          if (enable) begin
            r_state <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (!enable) begin
            // Abandon the frame; the held pair survives for the restart.
            r_state  <= ST_IDLE;
            r_div    <= '0;
            r_bitcnt <= '0;
            r_bclk   <= 1'b0;
            r_lrclk  <= 1'b0;
            r_dout   <= 1'b0;
          end else if (w_tick) begin
            r_div  <= '0;
            r_bclk <= ~r_bclk;
            if (r_bclk) begin
              r_bitcnt <= w_bit_next;
              r_lrclk  <= w_lr_next;
              if (!w_data_slot) begin
                r_dout <= 1'b0;
              end else if (w_lr_next) begin
                r_dout     <= r_sh_right[DATA_WIDTH-1];
                r_sh_right <= r_sh_right << 1;
              end else begin
                r_dout    <= r_sh_left[DATA_WIDTH-1];
                r_sh_left <= r_sh_left << 1;
              end
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready = w_ready;
  assign bclk     = r_bclk;
  assign lrclk    = r_lrclk;
  assign dout     = r_dout;
  assign underrun = r_underrun;

endmodule
